// File: rtl/matrix_frame_buffer.sv
// Double-buffered 8x8 R/G frame store: pixel writes and an 8-cycle clear engine
// target the hidden back buffer, and a swap atomically exposes it on frame_o.
module matrix_frame_buffer #(
  parameter bit COPY_ON_SWAP = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_en,
  input  logic [2:0]   wr_row,
  input  logic [2:0]   wr_col,
  input  logic [1:0]   wr_rgb,
  output logic         wr_drop,
  input  logic         clr_req,
  input  logic [1:0]   clr_rgb,
  input  logic         swap_req,
  output logic         swap_ack,
  output logic         busy,
  output logic [127:0] frame_o
);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t         state_q, state_d;
  logic [127:0]   front_q, front_d;
  logic [127:0]   back_q, back_d;
  logic [2:0]     cnt_q, cnt_d;
  logic [1:0]     clr_rgb_q, clr_rgb_d;
  logic           pend_swap_q, pend_swap_d;
  logic           pend_clr_q, pend_clr_d;
  logic           swap_ack_d;

  // Row r lives at bits (7-r)*16 +: 16, so the base index is just {~r, c, 0}.
  logic [6:0] wr_idx;
  logic [6:0] clr_idx;
  assign wr_idx  = {~wr_row, wr_col, 1'b0};
  assign clr_idx = {~cnt_q, 4'b0000};

  // NOTE: every variable written here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    front_d     = front_q;
    back_d      = back_q;
    cnt_d       = cnt_q;
    clr_rgb_d   = clr_rgb_q;
    pend_swap_d = pend_swap_q;
    pend_clr_d  = pend_clr_q;
    swap_ack_d  = 1'b0;
    wr_drop     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (wr_en) back_d[wr_idx +: 2] = wr_rgb;

        if (swap_req || pend_swap_q) begin
          // back_d already carries this cycle's write, so it is merged into the new front.
          front_d     = back_d;
          if (!COPY_ON_SWAP) back_d = front_q;
          pend_swap_d = 1'b0;
          swap_ack_d  = 1'b1;
          if (clr_req) begin
            pend_clr_d = 1'b1;
            clr_rgb_d  = clr_rgb;
          end
        end else if (clr_req || pend_clr_q) begin
          if (clr_req) clr_rgb_d = clr_rgb;
          pend_clr_d = 1'b0;
          cnt_d      = 3'd0;
          state_d    = CLEAR;
        end
      end

      CLEAR: begin
        back_d[clr_idx +: 16] = {8{clr_rgb_q}};
        wr_drop = wr_en;
        if (swap_req) pend_swap_d = 1'b1;
        if (clr_req) begin
          cnt_d     = 3'd0;
          clr_rgb_d = clr_rgb;
        end else if (cnt_q == 3'd7) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      front_q     <= '0;
      back_q      <= '0;
      cnt_q       <= '0;
      clr_rgb_q   <= '0;
      pend_swap_q <= 1'b0;
      pend_clr_q  <= 1'b0;
      swap_ack    <= 1'b0;
    end else begin
      state_q     <= state_d;
      front_q     <= front_d;
      back_q      <= back_d;
      cnt_q       <= cnt_d;
      clr_rgb_q   <= clr_rgb_d;
      pend_swap_q <= pend_swap_d;
      pend_clr_q  <= pend_clr_d;
      swap_ack    <= swap_ack_d;
    end
  end

  assign busy    = (state_q == CLEAR) || pend_clr_q || pend_swap_q;
  assign frame_o = front_q;

endmodule

// File: tb/tb_matrix_frame_buffer.sv
// Directed bench for matrix_frame_buffer: writes, swaps, clears, pending
// requests and asynchronous reset, checked against hand-computed frames.
module tb_matrix_frame_buffer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         wr_en;
  logic [2:0]   wr_row, wr_col;
  logic [1:0]   wr_rgb;
  logic         wr_drop;
  logic         clr_req;
  logic [1:0]   clr_rgb;
  logic         swap_req;
  logic         swap_ack;
  logic         busy;
  logic [127:0] frame_o;

  int n_cmp = 0;
  int n_bad = 0;

  matrix_frame_buffer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_row   (wr_row),
    .wr_col   (wr_col),
    .wr_rgb   (wr_rgb),
    .wr_drop  (wr_drop),
    .clr_req  (clr_req),
    .clr_rgb  (clr_rgb),
    .swap_req (swap_req),
    .swap_ack (swap_ack),
    .busy     (busy),
    .frame_o  (frame_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] px(input int r, input int c, input logic [1:0] rgb);
    logic [127:0] v;
    v = '0;
    v[(7 - r) * 16 + 2 * c +: 2] = rgb;
    return v;
  endfunction

  logic [127:0] exp_frame;

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_row = '0; wr_col = '0; wr_rgb = '0;
    clr_req = 1'b0; clr_rgb = '0; swap_req = 1'b0;
    repeat (2) tick();
    check("rst_frame", frame_o, '0);
    check("rst_ack", {127'b0, swap_ack}, '0);
    check("rst_busy", {127'b0, busy}, '0);
    check("rst_drop", {127'b0, wr_drop}, '0);
    rst_n = 1'b1;
    tick();

    // 1: single pixel write then swap
    wr_en = 1'b1; wr_row = 3'd0; wr_col = 3'd0; wr_rgb = 2'b01;
    tick();
    wr_en = 1'b0;
    check("t1_hidden", frame_o, '0);
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    exp_frame = 128'd1 << 112;
    check("t1_frame", frame_o, exp_frame);
    check("t1_ack", {127'b0, swap_ack}, 128'd1);
    tick();
    check("t1_ack_pulse", {127'b0, swap_ack}, '0);

    // 2: write stays invisible until the next swap
    wr_en = 1'b1; wr_row = 3'd7; wr_col = 3'd7; wr_rgb = 2'b11;
    tick();
    wr_en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      check("t2_hold", frame_o, exp_frame);
      tick();
    end
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    exp_frame = exp_frame | (128'd3 << 14);
    check("t2_frame", frame_o, exp_frame);

    // 3: clear to green-only colour 2'b10
    clr_req = 1'b1; clr_rgb = 2'b10;
    tick();
    clr_req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("t3_busy", {127'b0, busy}, 128'd1);
      tick();
    end
    check("t3_idle", {127'b0, busy}, '0);
    check("t3_front_kept", frame_o, exp_frame);
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    exp_frame = {64{2'b10}};
    check("t3_frame", frame_o, exp_frame);

    // 4: write during clear cycle 3 is dropped
    clr_req = 1'b1; clr_rgb = 2'b01;
    tick();
    clr_req = 1'b0;
    repeat (3) tick();
    wr_en = 1'b1; wr_row = 3'd2; wr_col = 3'd5; wr_rgb = 2'b10;
    #1;
    check("t4_drop", {127'b0, wr_drop}, 128'd1);
    tick();
    wr_en = 1'b0;
    #1;
    check("t4_drop_pulse", {127'b0, wr_drop}, '0);
    repeat (4) tick();
    check("t4_idle", {127'b0, busy}, '0);
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    exp_frame = {64{2'b01}};
    check("t4_frame", frame_o, exp_frame);
    check("t4_pixel_absent", frame_o & px(2, 5, 2'b11), px(2, 5, 2'b01));

    // 5: swap requested mid-clear is deferred to the first idle cycle
    clr_req = 1'b1; clr_rgb = 2'b11;
    tick();
    clr_req = 1'b0;
    repeat (2) tick();
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("t5_no_ack", {127'b0, swap_ack}, '0);
      check("t5_front_hold", frame_o, exp_frame);
      tick();
    end
    check("t5_pending_busy", {127'b0, busy}, 128'd1);
    check("t5_no_ack_idle", {127'b0, swap_ack}, '0);
    tick();
    exp_frame = {64{2'b11}};
    check("t5_ack", {127'b0, swap_ack}, 128'd1);
    check("t5_frame", frame_o, exp_frame);

    // 6: simultaneous swap+clear, then async reset during the clear
    wr_en = 1'b1; wr_row = 3'd4; wr_col = 3'd3; wr_rgb = 2'b00;
    swap_req = 1'b1; clr_req = 1'b1; clr_rgb = 2'b00;
    tick();
    wr_en = 1'b0; swap_req = 1'b0; clr_req = 1'b0;
    exp_frame = {64{2'b11}} & ~px(4, 3, 2'b11);
    check("t6_ack", {127'b0, swap_ack}, 128'd1);
    check("t6_frame", frame_o, exp_frame);
    check("t6_pend_busy", {127'b0, busy}, 128'd1);
    tick();
    check("t6_ack_pulse", {127'b0, swap_ack}, '0);
    check("t6_clear_busy", {127'b0, busy}, 128'd1);
    repeat (2) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_frame", frame_o, '0);
    check("t6_rst_ack", {127'b0, swap_ack}, '0);
    check("t6_rst_busy", {127'b0, busy}, '0);
    check("t6_rst_drop", {127'b0, wr_drop}, '0);
    tick();
    rst_n = 1'b1;
    tick();
    check("t6_post_busy", {127'b0, busy}, '0);
    check("t6_post_ack", {127'b0, swap_ack}, '0);
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    check("t6_back_zero", frame_o, '0);
    check("t6_post_swap_ack", {127'b0, swap_ack}, 128'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
